// File: rtl/axi_sram_slave.sv
// AXI3-style single-outstanding SRAM responder backed by a word-addressed
// register array. One read or write burst at a time, registered handshakes,
// alternating priority when reads and writes contend.
//
// Handshake rule for every channel: a beat transfers on a rising edge where
// valid and ready are both 1; the source holds its payload stable while
// valid is high and ready is low.
module axi_sram_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int MEM_AW = 14,
    parameter logic [ADDR_W-1:0] BASE = ADDR_W'(32'h1c00_0000)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_AR_ACC = 3'd1;
    localparam logic [2:0] S_RD     = 3'd2;
    localparam logic [2:0] S_AW_ACC = 3'd3;
    localparam logic [2:0] S_WR     = 3'd4;
    localparam logic [2:0] S_WRESP  = 3'd5;

    logic [2:0]        state;
    logic              prio_wr;   // 1: write wins the next contended grant
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              err;       // sticky write error for the current burst

    logic [31:0] mem [2**MEM_AW];

    logic [ADDR_W-1:0] nxt_addr;
    logic              w_hs;
    logic              w_last_cnt;
    logic              w_bad;
    logic              mem_we;

    // Side-band attributes have no effect on this responder.
    logic unused_sideband;
    assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot};

    assign dbg_state = state;

    function automatic logic in_win(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:MEM_AW+2] == BASE[ADDR_W-1:MEM_AW+2];
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] a,
        input logic [LEN_W-1:0]  len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        logic              wrap_ok;
        inc  = a + (ADDR_W'(1) << size);
        // Wrap container is (len+1)*step bytes; only power-of-two beat counts wrap.
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        wrap_ok = (burst == 2'b10) &&
                  (len == LEN_W'(1) || len == LEN_W'(3) ||
                   len == LEN_W'(7) || len == LEN_W'(15));
        if (burst == 2'b00)
            return a;
        else if (wrap_ok)
            return (a & ~mask) | (inc & mask);
        else
            return inc;
    endfunction

    assign nxt_addr   = next_addr(addr_q, len_q, size_q, burst_q);
    assign w_hs       = (state == S_WR) && wvalid && wready;
    assign w_last_cnt = (cnt == len_q);
    assign w_bad      = (wlast != w_last_cnt) || (wid != id_q) || !in_win(addr_q);
    assign mem_we     = w_hs && in_win(addr_q);

    // Byte-masked memory write; contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i])
                    mem[addr_q[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Transaction FSM and all registered channel outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            prio_wr <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt     <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err     <= 1'b0;
            arready <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            rlast   <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arvalid && (!awvalid || !prio_wr)) begin
                        state   <= S_AR_ACC;
                        arready <= 1'b1;
                        prio_wr <= 1'b1;
                    end else if (awvalid) begin
                        state   <= S_AW_ACC;
                        awready <= 1'b1;
                        prio_wr <= 1'b0;
                    end
                end
                S_AR_ACC: begin
                    arready <= 1'b0;
                    id_q    <= arid;
                    addr_q  <= araddr;
                    len_q   <= arlen;
                    size_q  <= arsize;
                    burst_q <= arburst;
                    cnt     <= '0;
                    rvalid  <= 1'b1;
                    rid     <= arid;
                    rlast   <= (arlen == '0);
                    rdata   <= in_win(araddr) ? mem[araddr[MEM_AW+1:2]] : 32'h0;
                    rresp   <= (!in_win(araddr) || arburst == 2'b11) ? 2'b10 : 2'b00;
                    state   <= S_RD;
                end
                S_RD: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            addr_q <= nxt_addr;
                            cnt    <= cnt + LEN_W'(1);
                            rlast  <= ((cnt + LEN_W'(1)) == len_q);
                            rdata  <= in_win(nxt_addr) ? mem[nxt_addr[MEM_AW+1:2]] : 32'h0;
                            rresp  <= (!in_win(nxt_addr) || burst_q == 2'b11) ? 2'b10 : 2'b00;
                        end
                    end
                end
                S_AW_ACC: begin
                    awready <= 1'b0;
                    id_q    <= awid;
                    addr_q  <= awaddr;
                    len_q   <= awlen;
                    size_q  <= awsize;
                    burst_q <= awburst;
                    cnt     <= '0;
                    err     <= (awburst == 2'b11);
                    wready  <= 1'b1;
                    state   <= S_WR;
                end
                S_WR: begin
                    if (w_hs) begin
                        if (w_last_cnt) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= (err || w_bad) ? 2'b10 : 2'b00;
                            state  <= S_WRESP;
                        end else begin
                            err    <= err || w_bad;
                            addr_q <= nxt_addr;
                            cnt    <= cnt + LEN_W'(1);
                        end
                    end
                end
                S_WRESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single/INCR/WRAP/FIXED bursts, byte
// strobes, arbitration order, decode and protocol errors, reset mid-burst.
module tb_axi_sram_slave;

    localparam logic [31:0] BASE = 32'h1c00_0000;

    logic        aclk, aresetn;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic        bvalid, bready;
    logic [2:0]  dbg_state;

    axi_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_state(dbg_state)
    );

    // Clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    int          ar_wait;
    time         ar_t, aw_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge aclk);
        aresetn = 1'b0;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        rready = 1'b0; bready = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input bit toggle);
        int n, cyc;
        logic stalled;
        logic [31:0] sd;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst;
        arvalid = 1'b1;
        ar_wait = 0;
        do begin
            @(negedge aclk);
            ar_wait++;
        end while (!arready && ar_wait < 50);
        if (!arready) begin
            check("ar_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            return;
        end
        ar_t = $time;
        @(negedge aclk);
        arvalid = 1'b0;
        check("rvalid_after_ar", {31'd0, rvalid}, 32'd1);
        n = 0; cyc = 0; stalled = 1'b0; sd = '0;
        while (n <= int'(len) && cyc < 200) begin
            rready = toggle ? cyc[0] : 1'b1;
            if (stalled) begin
                check("stall_hold", rdata, sd);
                stalled = 1'b0;
            end
            if (rvalid && rready) begin
                rd_data[n] = rdata; rd_resp[n] = rresp; rd_last[n] = rlast; rd_id = rid;
                n++;
            end else if (rvalid) begin
                stalled = 1'b1;
                sd = rdata;
            end
            @(negedge aclk);
            cyc++;
        end
        rready = 1'b0;
        if (n <= int'(len)) check("r_timeout", n, int'(len) + 1);
        check("rvalid_drop", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] strb, input int early);
        int b, cyc, waitc;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst;
        awvalid = 1'b1;
        waitc = 0;
        do begin
            @(negedge aclk);
            waitc++;
        end while (!awready && waitc < 50);
        if (!awready) begin
            check("aw_timeout", 32'd0, 32'd1);
            awvalid = 1'b0;
            return;
        end
        aw_t = $time;
        @(negedge aclk);
        awvalid = 1'b0;
        b = 0; cyc = 0;
        while (b <= int'(len) && cyc < 200) begin
            wvalid = 1'b1; wdata = wr_data[b]; wstrb = strb; wid = id;
            wlast = (early >= 0) ? (b == early) : (b == int'(len));
            if (wready) b++;
            @(negedge aclk);
            cyc++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (b <= int'(len)) check("w_timeout", b, int'(len) + 1);
        bready = 1'b1;
        cyc = 0;
        while (!bvalid && cyc < 50) begin
            @(negedge aclk);
            cyc++;
        end
        if (!bvalid) check("b_timeout", 32'd0, 32'd1);
        b_resp = bresp; b_id = bid;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    initial begin
        int n, cyc;
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_outputs", {27'd0, arready, awready, rvalid, wready, bvalid}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        aresetn = 1'b1;

        // Preload word 0, then single read
        wr_data[0] = 32'hDEADBEEF;
        axi_write(4'd1, BASE, 8'd0, 2'b01, 4'hF, -1);
        check("pre_bresp", {30'd0, b_resp}, 32'd0);
        check("pre_bid", {28'd0, b_id}, 32'd1);
        axi_read(4'd3, BASE, 8'd0, 2'b01, 1'b0);
        check("single_ar_lat", ar_wait, 32'd1);
        check("single_data", rd_data[0], 32'hDEADBEEF);
        check("single_rid", {28'd0, rd_id}, 32'd3);
        check("single_rlast", {31'd0, rd_last[0]}, 32'd1);
        check("single_rresp", {30'd0, rd_resp[0]}, 32'd0);

        // INCR write then read, plain and stalled
        for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
        axi_write(4'd5, BASE + 32'h10, 8'd3, 2'b01, 4'hF, -1);
        check("incr_bresp", {30'd0, b_resp}, 32'd0);
        check("incr_bid", {28'd0, b_id}, 32'd5);
        for (int pass = 0; pass < 2; pass++) begin
            axi_read(4'd6, BASE + 32'h10, 8'd3, 2'b01, pass == 1);
            for (int i = 0; i < 4; i++) begin
                check("incr_data", rd_data[i], 32'(i + 1));
                check("incr_rlast", {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
            end
        end

        // Byte strobes
        wr_data[0] = 32'hAABBCCDD;
        axi_write(4'd2, BASE + 32'h20, 8'd0, 2'b01, 4'hF, -1);
        wr_data[0] = 32'h11223344;
        axi_write(4'd2, BASE + 32'h20, 8'd0, 2'b01, 4'b0101, -1);
        axi_read(4'd2, BASE + 32'h20, 8'd0, 2'b01, 1'b0);
        check("strobe_data", rd_data[0], 32'hAA22CC44);

        // WRAP read over words 12..15
        wr_data[0] = 32'hA; wr_data[1] = 32'hB; wr_data[2] = 32'hC; wr_data[3] = 32'hD;
        axi_write(4'd4, BASE + 32'h30, 8'd3, 2'b01, 4'hF, -1);
        axi_read(4'd4, BASE + 32'h38, 8'd3, 2'b10, 1'b0);
        check("wrap_b0", rd_data[0], 32'hC);
        check("wrap_b1", rd_data[1], 32'hD);
        check("wrap_b2", rd_data[2], 32'hA);
        check("wrap_b3", rd_data[3], 32'hB);

        // FIXED read repeats the same word
        axi_read(4'd1, BASE + 32'h10, 8'd1, 2'b00, 1'b0);
        check("fixed_b0", rd_data[0], 32'd1);
        check("fixed_b1", rd_data[1], 32'd1);
        check("fixed_rlast", {31'd0, rd_last[1]}, 32'd1);

        // Contention right after reset: read first, then write
        reset_dut();
        wr_data[0] = 32'h77;
        fork
            axi_read(4'd8, BASE, 8'd0, 2'b01, 1'b0);
            axi_write(4'd9, BASE + 32'h40, 8'd0, 2'b01, 4'hF, -1);
        join
        check("arb_order", {31'd0, ar_t < aw_t}, 32'd1);
        check("arb_rdata", rd_data[0], 32'hDEADBEEF);
        check("arb_bresp", {30'd0, b_resp}, 32'd0);
        check("arb_bid", {28'd0, b_id}, 32'd9);
        axi_read(4'd9, BASE + 32'h40, 8'd0, 2'b01, 1'b0);
        check("arb_wdata", rd_data[0], 32'h77);

        // Out-of-window accesses
        wr_data[0] = 32'h12345678;
        axi_write(4'd3, BASE + 32'h0010_0000, 8'd0, 2'b01, 4'hF, -1);
        check("oow_bresp", {30'd0, b_resp}, 32'd2);
        axi_read(4'd3, BASE, 8'd0, 2'b01, 1'b0);
        check("oow_mem_kept", rd_data[0], 32'hDEADBEEF);
        axi_read(4'd3, BASE + 32'h0010_0000, 8'd0, 2'b01, 1'b0);
        check("oow_rdata", rd_data[0], 32'd0);
        check("oow_rresp", {30'd0, rd_resp[0]}, 32'd2);

        // Early wlast
        for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 16);
        axi_write(4'd7, BASE + 32'h80, 8'd3, 2'b01, 4'hF, 1);
        check("early_wlast_bresp", {30'd0, b_resp}, 32'd2);
        check("early_wlast_bid", {28'd0, b_id}, 32'd7);

        // Reset during beat 2 of a 4-beat read
        @(negedge aclk);
        arid = 4'd1; araddr = BASE + 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        cyc = 0;
        do begin
            @(negedge aclk);
            cyc++;
        end while (!arready && cyc < 50);
        @(negedge aclk);
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 50) begin
            if (rvalid) n++;
            @(negedge aclk);
            cyc++;
        end
        check("mid_beats", n, 32'd2);
        check("mid_rvalid_pre", {31'd0, rvalid}, 32'd1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_outputs", {28'd0, rvalid, arready, wready, bvalid}, 32'd0);
        rready = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        axi_read(4'd2, BASE, 8'd0, 2'b01, 1'b0);
        check("post_rst_data", rd_data[0], 32'hDEADBEEF);
        check("post_rst_rresp", {30'd0, rd_resp[0]}, 32'd0);
        check("post_rst_rlast", {31'd0, rd_last[0]}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
